pkt_rr_sched: RTL and testbench
===============================

Name: pkt_rr_sched

Overview:
- Packet-granular round-robin scheduler that merges NUM_IN Avalon-ST packet streams onto one output stream.
- Paces grants on the downstream out_almost_full signal and switches inputs only at packet boundaries.
- Inserts at least one idle cycle between consecutive output packets.
- Sits between per-port packet FIFOs and a shared downstream FIFO or pipeline.

Parameters:
- NUM_IN, 4, number of input streams (2..16).
- DWIDTH, 512, data bus width.
- EWIDTH, 6, empty field width.
- CWIDTH, $clog2(NUM_IN), width of the channel index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  NUM_IN*DWIDTH  packed data; input i occupies slice [i*DWIDTH +: DWIDTH].
- in_sop  in  NUM_IN  start of packet, per input.
- in_eop  in  NUM_IN  end of packet, per input.
- in_empty  in  NUM_IN*EWIDTH  packed empty field, per input.
- in_valid  in  NUM_IN  beat valid, per input.
- in_ready  out  NUM_IN  beat accept, per input.
- out_data  out  DWIDTH  merged data.
- out_sop  out  1  merged start of packet.
- out_eop  out  1  merged end of packet.
- out_empty  out  EWIDTH  merged empty.
- out_valid  out  1  merged beat valid.
- out_chan  out  CWIDTH  source input index of the current output beat.
- out_almost_full  in  1  downstream almost-full.

Behaviour:
- States: IDLE, SEND. Registers: grant[CWIDTH], last[CWIDTH].
- in_ready[i] = (state==SEND) && (grant==i). This is combinational from registers only; there is no input→in_ready path.
- A beat is accepted when in_valid[i] && in_ready[i].
- IDLE → SEND when !out_almost_full && |in_valid:
  - grant <= first index j with in_valid[j], searching last+1, last+2, ... mod NUM_IN;
  - last <= j.
- IDLE with out_almost_full=1 or no in_valid: stay in IDLE; grant and last hold.
- SEND → IDLE on an accepted beat with in_eop[grant]=1.
- SEND with in_valid[grant]=0: stay in SEND, emit out_valid=0 (bubble). A packet is never abandoned.
- out_almost_full is sampled only in IDLE. Assertion mid-packet does not stall the packet; downstream absorbs the remainder.
- Output registered, latency 1:
  - out_valid <= accepted;
  - out_sop, out_eop, out_empty <= granted input's fields when accepted, else 0;
  - out_data <= granted input's data every cycle (don't-care when out_valid=0);
  - out_chan <= grant.
- Timing, eop accepted at cycle t:
  - eop beat appears on the output at t+1;
  - state is IDLE at t+1;
  - earliest next sop is accepted at t+2 and appears at t+3;
  - minimum one idle output cycle between packets.
- Inputs present packets starting with sop; sop is not checked.
- Single-beat packets (sop && eop) take one SEND cycle.
- NUM_IN not a power of 2: the mod wrap is explicit (last == NUM_IN-1 → search starts at 0).
- Reset values:
  - state=IDLE; last=NUM_IN-1, so input 0 has first priority; grant=0;
  - out_valid, out_sop, out_eop, out_empty, out_chan = 0; in_ready = 0.
- Reset mid-packet: state returns to IDLE and out_valid=0 from the next cycle. The truncated packet is not completed; the upstream FIFO is reset together with this block.

Optional Feature:
- PKT_RR_SCHED_STATS_EN defined:
  - adds output stat_pkt_cnt, NUM_IN*32;
  - counter i increments by 1 on each accepted eop beat from input i, wraps 2^32-1 → 0, and resets to 0.
- Undefined: port and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Single 3-beat packet on input 2, out_almost_full=0 from reset → in_ready[2] high from cycle 2; out_valid high for 3 consecutive cycles; out_chan=2; sop on beat 1, eop on beat 3 with the input empty value (e.g. 5).
- All 4 inputs continuously offering 2-beat packets → output order 0,1,2,3,0,1...; exactly 1 idle output cycle between packets; no beats interleaved.
- out_almost_full=1 with input 1 valid → in_ready stays 0 and out_valid stays 0. Deassert → grant within 1 cycle and packet forwarded intact.
- out_almost_full rises during beat 2 of a 4-beat packet → remaining beats 3–4 still forwarded; next packet withheld until deassert.
- in_valid gap of 2 cycles mid-packet on input 0 while input 3 also valid → 2 bubbles on the output, input 3 not granted until input 0's eop; out_chan=0 throughout.
- rst pulse during beat 2 of a packet → next cycle out_valid=0 and in_ready=0. With STATS_EN, counters read 0 after reset and count 1 after one full packet on input 1.

Source files
------------

// File: rtl/pkt_rr_sched_if.sv
// Packet stream bundle for pkt_rr_sched: NUM_IN packed Avalon-ST inputs and one merged output.
// master drives the inputs and almost-full; slave is the scheduler's view.
interface pkt_rr_sched_if #(
   parameter int NUM_IN = 4,
   parameter int DWIDTH = 512,
   parameter int EWIDTH = 6,
   parameter int CWIDTH = $clog2(NUM_IN)
);
   logic [NUM_IN*DWIDTH-1:0] in_data;
   logic [NUM_IN-1:0]        in_sop;
   logic [NUM_IN-1:0]        in_eop;
   logic [NUM_IN*EWIDTH-1:0] in_empty;
   logic [NUM_IN-1:0]        in_valid;
   logic [NUM_IN-1:0]        in_ready;
   logic [DWIDTH-1:0]        out_data;
   logic                     out_sop;
   logic                     out_eop;
   logic [EWIDTH-1:0]        out_empty;
   logic                     out_valid;
   logic [CWIDTH-1:0]        out_chan;
   logic                     out_almost_full;

   modport master (
      output in_data, in_sop, in_eop, in_empty, in_valid, out_almost_full,
      input  in_ready, out_data, out_sop, out_eop, out_empty, out_valid, out_chan
   );

   modport slave (
      input  in_data, in_sop, in_eop, in_empty, in_valid, out_almost_full,
      output in_ready, out_data, out_sop, out_eop, out_empty, out_valid, out_chan
   );
endinterface

// File: rtl/pkt_rr_sched.sv
// Packet-granular round-robin merge of NUM_IN streams, paced by downstream almost-full.
// Optional per-input packet counters when PKT_RR_SCHED_STATS_EN is defined.
module pkt_rr_sched #(
   parameter int NUM_IN = 4,
   parameter int DWIDTH = 512,
   parameter int EWIDTH = 6,
   parameter int CWIDTH = $clog2(NUM_IN)
) (
   input  logic clk,
   input  logic rst,
   pkt_rr_sched_if.slave bus
`ifdef PKT_RR_SCHED_STATS_EN
   ,
   output logic [NUM_IN*32-1:0] stat_pkt_cnt
`endif
);
   typedef enum logic {IDLE, SEND} state_t;

   state_t            state, state_nxt;
   logic [CWIDTH-1:0] grant, grant_nxt;
   logic [CWIDTH-1:0] last, last_nxt;
   logic [CWIDTH-1:0] pick;
   logic              found;
   int                idx;

   logic              accepted;
   logic              g_sop, g_eop;
   logic [EWIDTH-1:0] g_empty;
   logic [DWIDTH-1:0] g_data;

   // Search starts just after the last winner; the wrap is explicit so
   // non-power-of-2 NUM_IN never yields an out-of-range index.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NUM_IN; k++) begin
         idx = int'(last) + k;
         if (idx >= NUM_IN) idx = idx - NUM_IN;
         if (!found && bus.in_valid[idx]) begin
            found = 1'b1;
            pick  = CWIDTH'(idx);
         end
      end
   end

   assign g_data   = bus.in_data[int'(grant)*DWIDTH +: DWIDTH];
   assign g_empty  = bus.in_empty[int'(grant)*EWIDTH +: EWIDTH];
   assign g_sop    = bus.in_sop[grant];
   assign g_eop    = bus.in_eop[grant];
   assign accepted = (state == SEND) && bus.in_valid[grant];

   always_comb begin
      bus.in_ready = '0;
      if (state == SEND) bus.in_ready[grant] = 1'b1;
   end

   // Almost-full only gates the start of a packet; once granted, a packet runs to eop.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (!bus.out_almost_full && found) begin
               state_nxt = SEND;
               grant_nxt = pick;
               last_nxt  = pick;
            end
         end
         SEND: begin
            if (accepted && g_eop) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         grant         <= '0;
         last          <= CWIDTH'(NUM_IN - 1);
         bus.out_valid <= 1'b0;
         bus.out_sop   <= 1'b0;
         bus.out_eop   <= 1'b0;
         bus.out_empty <= '0;
         bus.out_chan  <= '0;
      end else begin
         state         <= state_nxt;
         grant         <= grant_nxt;
         last          <= last_nxt;
         bus.out_valid <= accepted;
         bus.out_sop   <= accepted & g_sop;
         bus.out_eop   <= accepted & g_eop;
         bus.out_empty <= accepted ? g_empty : '0;
         bus.out_chan  <= grant;
      end
   end

   always_ff @(posedge clk) bus.out_data <= g_data;

`ifdef PKT_RR_SCHED_STATS_EN
   for (genvar i = 0; i < NUM_IN; i++) begin : g_stat
      logic [31:0] cnt;
      always_ff @(posedge clk) begin
         if (rst) cnt <= '0;
         else if (accepted && g_eop && grant == CWIDTH'(i)) cnt <= cnt + 32'd1;
      end
      assign stat_pkt_cnt[i*32 +: 32] = cnt;
   end
`endif
endmodule

// File: tb/tb_pkt_rr_sched.sv
// Directed + random bench for pkt_rr_sched against a queue-based scheduling model.
// Honours PKT_RR_SCHED_STATS_EN when defined.
module tb_pkt_rr_sched;
   localparam int NUM_IN = 4;
   localparam int DWIDTH = 512;
   localparam int EWIDTH = 6;
   localparam int CWIDTH = $clog2(NUM_IN);

   typedef struct packed {
      logic [DWIDTH-1:0] data;
      logic              sop;
      logic              eop;
      logic [EWIDTH-1:0] empty;
   } beat_t;

   logic clk, rst;
   pkt_rr_sched_if #(.NUM_IN(NUM_IN), .DWIDTH(DWIDTH), .EWIDTH(EWIDTH), .CWIDTH(CWIDTH)) bus ();
`ifdef PKT_RR_SCHED_STATS_EN
   logic [NUM_IN*32-1:0] stat_pkt_cnt;
`endif

   pkt_rr_sched #(.NUM_IN(NUM_IN), .DWIDTH(DWIDTH), .EWIDTH(EWIDTH), .CWIDTH(CWIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef PKT_RR_SCHED_STATS_EN
      , .stat_pkt_cnt (stat_pkt_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   beat_t       q[NUM_IN][$];
   bit          gate[NUM_IN];
   bit          m_send;
   int          m_grant, m_last;
   logic [31:0] m_cnt[NUM_IN];
   int          sop_log[$];
   int          gap_viol = 0;
   bit          prev_eop = 0;

   task automatic chk(input string tag, input logic [DWIDTH-1:0] obs, input logic [DWIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DWIDTH-1:0] rand_data();
      logic [DWIDTH-1:0] d;
      for (int k = 0; k < DWIDTH/32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic add_pkt(input int ch, input int n, input int emp);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.data  = rand_data();
         b.sop   = (k == 0);
         b.eop   = (k == n-1);
         b.empty = (k == n-1) ? EWIDTH'(emp) : EWIDTH'($urandom_range(0, 63));
         q[ch].push_back(b);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NUM_IN; i++) begin
         if (q[i].size() > 0) begin
            bus.in_data[i*DWIDTH +: DWIDTH]  = q[i][0].data;
            bus.in_sop[i]                    = q[i][0].sop;
            bus.in_eop[i]                    = q[i][0].eop;
            bus.in_empty[i*EWIDTH +: EWIDTH] = q[i][0].empty;
            bus.in_valid[i]                  = gate[i];
         end else begin
            bus.in_data[i*DWIDTH +: DWIDTH]  = '0;
            bus.in_sop[i]                    = 1'b0;
            bus.in_eop[i]                    = 1'b0;
            bus.in_empty[i*EWIDTH +: EWIDTH] = '0;
            bus.in_valid[i]                  = 1'b0;
         end
      end
   endtask

   function automatic bit busy();
      bit b = m_send;
      for (int i = 0; i < NUM_IN; i++) if (q[i].size() > 0) b = 1;
      return b;
   endfunction

   // One clock: predict from the rules, clock, then compare registered outputs.
   task automatic step();
      logic [NUM_IN-1:0] exp_rdy;
      logic [NUM_IN*32-1:0] exp_stat;
      bit acc, e_valid, e_sop, e_eop, hit;
      logic [EWIDTH-1:0] e_empty;
      logic [DWIDTH-1:0] e_data;
      int e_chan, g_old, j;
      beat_t hd;
      drive();
      #2;
      exp_rdy = '0;
      if (m_send) exp_rdy[m_grant] = 1'b1;
      chk("in_ready", bus.in_ready, exp_rdy);
      g_old = m_grant;
      hd    = (q[g_old].size() > 0) ? q[g_old][0] : '0;
      acc   = m_send && bus.in_valid[g_old];
      if (rst) begin
         acc = 0; e_valid = 0; e_sop = 0; e_eop = 0; e_empty = '0; e_chan = 0; e_data = '0;
         m_send = 0; m_grant = 0; m_last = NUM_IN - 1;
         for (int i = 0; i < NUM_IN; i++) m_cnt[i] = '0;
      end else begin
         e_valid = acc;
         e_sop   = acc && hd.sop;
         e_eop   = acc && hd.eop;
         e_empty = acc ? hd.empty : '0;
         e_chan  = m_grant;
         e_data  = hd.data;
         if (!m_send) begin
            if (!bus.out_almost_full && |bus.in_valid) begin
               hit = 0;
               for (int k = 1; k <= NUM_IN; k++) begin
                  j = (m_last + k) % NUM_IN;
                  if (!hit && bus.in_valid[j]) begin
                     hit = 1; m_send = 1; m_grant = j; m_last = j;
                  end
               end
            end
         end else if (acc && hd.eop) begin
            m_send = 0;
            m_cnt[g_old] = m_cnt[g_old] + 32'd1;
         end
      end
      @(posedge clk);
      #1;
      if (acc) void'(q[g_old].pop_front());
      chk("out_valid", bus.out_valid, e_valid);
      chk("out_sop", bus.out_sop, e_sop);
      chk("out_eop", bus.out_eop, e_eop);
      chk("out_empty", bus.out_empty, e_empty);
      chk("out_chan", bus.out_chan, e_chan);
      if (e_valid) chk("out_data", bus.out_data, e_data);
`ifdef PKT_RR_SCHED_STATS_EN
      for (int i = 0; i < NUM_IN; i++) exp_stat[i*32 +: 32] = m_cnt[i];
      chk("stat_pkt_cnt", stat_pkt_cnt, exp_stat);
`else
      exp_stat = '0;
`endif
      if (bus.out_valid && bus.out_sop) begin
         sop_log.push_back(int'(bus.out_chan));
         if (prev_eop) gap_viol++;
      end
      prev_eop = bus.out_valid && bus.out_eop;
   endtask

   task automatic drain(input int maxc);
      int n = 0;
      while (busy() && n < maxc) begin
         step();
         n++;
      end
      chk("drain_done", busy(), 1'b0);
      step();
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < NUM_IN; i++) q[i].delete();
   endtask

   initial begin
      int n, gap;
      rst = 1'b1;
      bus.out_almost_full = 1'b0;
      for (int i = 0; i < NUM_IN; i++) gate[i] = 1;
      m_send = 0; m_grant = 0; m_last = NUM_IN - 1;
      for (int i = 0; i < NUM_IN; i++) m_cnt[i] = '0;
      drive();
      @(posedge clk);
      #1;
      step();
      rst = 1'b0;

      // single 3-beat packet on input 2, empty 5 on eop
      add_pkt(2, 3, 5);
      drain(20);

      // all inputs offering 2-beat packets: strict 0,1,2,3 order with gaps
      reset_pulse();
      sop_log.delete();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < NUM_IN; c++) add_pkt(c, 2, $urandom_range(0, 63));
      drain(100);
      chk("rr_count", sop_log.size(), 12);
      for (int k = 0; k < sop_log.size(); k++) chk("rr_order", sop_log[k], k % NUM_IN);
      chk("pkt_gap", gap_viol, 0);

      // almost-full held from idle blocks the grant
      bus.out_almost_full = 1'b1;
      add_pkt(1, 3, 7);
      repeat (6) step();
      chk("afull_hold", q[1].size(), 3);
      bus.out_almost_full = 1'b0;
      drain(20);

      // almost-full rising mid-packet does not stall it, but withholds the next
      add_pkt(0, 4, 9);
      add_pkt(1, 2, 2);
      n = 0;
      while (!(m_send && m_grant == 0 && q[0].size() == 3) && n < 20) begin
         step(); n++;
      end
      bus.out_almost_full = 1'b1;
      repeat (8) step();
      chk("afull_tail", q[0].size(), 0);
      chk("afull_withheld", q[1].size(), 2);
      bus.out_almost_full = 1'b0;
      drain(20);

      // 2-cycle valid gap on input 0 with input 3 pending
      add_pkt(0, 3, 4);
      n = 0;
      while (!(m_send && m_grant == 0) && n < 10) begin
         step(); n++;
      end
      add_pkt(3, 2, 1);
      gap = 0;
      n = 0;
      while (busy() && n < 40) begin
         gate[0] = !(q[0].size() == 2 && gap < 2);
         if (!gate[0]) gap++;
         step(); n++;
      end
      gate[0] = 1;
      chk("gap_used", gap, 2);
      chk("gap_drain", busy(), 1'b0);

      // reset during beat 2 of a packet, then one clean packet on input 1
      reset_pulse();
      add_pkt(1, 4, 3);
      n = 0;
      while (q[1].size() != 2 && n < 20) begin
         step(); n++;
      end
      reset_pulse();
      step();
      add_pkt(1, 3, 6);
      drain(20);
`ifdef PKT_RR_SCHED_STATS_EN
      chk("stat_in1", stat_pkt_cnt[63:32], 1);
      chk("stat_in0", stat_pkt_cnt[31:0], 0);
`endif

      // random traffic, gaps and almost-full
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            n = $urandom_range(0, NUM_IN - 1);
            if (q[n].size() < 12) add_pkt(n, $urandom_range(1, 5), $urandom_range(0, 63));
         end
         for (int i = 0; i < NUM_IN; i++) gate[i] = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) bus.out_almost_full = ~bus.out_almost_full;
         step();
      end
      for (int i = 0; i < NUM_IN; i++) gate[i] = 1;
      bus.out_almost_full = 1'b0;
      drain(400);
      chk("pkt_gap_final", gap_viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
